// File: rtl/w5300_reset_gen.sv
// W5300 hardware reset sequencer: minimum-width active-low reset pulse, PLL recovery wait, ready flag.
// Optional macro W5300_RESET_SYNC_EN adds a two-flop synchronizer on trigger_reset.
module w5300_reset_gen #(
  parameter int unsigned RESET_LOW_CYCLES = 250,
  parameter int unsigned RECOVERY_CYCLES  = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_reset,
  output logic w5300_resetl,
  output logic w5300_ready,
  output logic reset_done
);

  localparam int unsigned MAX_CYCLES = (RESET_LOW_CYCLES > RECOVERY_CYCLES) ?
                                       RESET_LOW_CYCLES : RECOVERY_CYCLES;
  localparam int unsigned CW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LOAD = CW'(RESET_LOW_CYCLES - 1);
  localparam logic [CW-1:0] REC_LOAD = CW'(RECOVERY_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RECOVER
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            resetl_q;
  logic            ready_q;
  logic            done_q;
  logic            trig_prev_q;
  logic            trig_s;
  logic            request;

`ifdef W5300_RESET_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], trigger_reset};
    end
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trigger_reset;
`endif

  assign request = trig_s & ~trig_prev_q;

  // RECOVER exits when the counter would hit zero, so ready rises exactly
  // RECOVERY_CYCLES edges after resetl; RECOVERY_CYCLES=0 skips RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ASSERT;
      cnt_q       <= LOW_LOAD;
      resetl_q    <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trig_s;
      done_q      <= 1'b0;
      if (request) begin
        state_q  <= ASSERT;
        cnt_q    <= LOW_LOAD;
        resetl_q <= 1'b0;
        ready_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            resetl_q <= 1'b1;
            ready_q  <= 1'b1;
          end
          ASSERT: begin
            if (cnt_q == '0) begin
              resetl_q <= 1'b1;
              if (RECOVERY_CYCLES == 0) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                state_q <= RECOVER;
                cnt_q   <= REC_LOAD;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          RECOVER: begin
            resetl_q <= 1'b1;
            if (cnt_q <= CW'(1)) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q  <= ASSERT;
            cnt_q    <= LOW_LOAD;
            resetl_q <= 1'b0;
            ready_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w5300_resetl = resetl_q;
  assign w5300_ready  = ready_q;
  assign reset_done   = done_q;

endmodule

// File: tb/tb_w5300_reset_gen.sv
// Bench for w5300_reset_gen: two instances (4/3 and boundary 1/0 cycles) checked every edge
// against an edge-time model (resetl rises L edges, ready L+R edges after the last restart).
module tb_w5300_reset_gen;

  localparam int unsigned L0 = 4;
  localparam int unsigned R0 = 3;
  localparam int unsigned L1 = 1;
  localparam int unsigned R1 = 0;

  logic clk = 1'b0;
  logic rst;
  logic trig;
  logic resetl_a, ready_a, done_a;
  logic resetl_b, ready_b, done_b;

  int n_checks = 0;
  int n_pass   = 0;

  longint edge_n = 0;
  longint low_end  [2];
  longint ready_at [2];
  longint lcyc     [2];
  longint rcyc     [2];
  logic   prev_trig = 1'b0;
  logic   hist1 = 1'b0;
  logic   hist2 = 1'b0;

  always #5 clk = ~clk;

  w5300_reset_gen #(
    .RESET_LOW_CYCLES(L0),
    .RECOVERY_CYCLES (R0)
  ) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .trigger_reset(trig),
    .w5300_resetl (resetl_a),
    .w5300_ready  (ready_a),
    .reset_done   (done_a)
  );

  w5300_reset_gen #(
    .RESET_LOW_CYCLES(L1),
    .RECOVERY_CYCLES (R1)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .trigger_reset(trig),
    .w5300_resetl (resetl_b),
    .w5300_ready  (ready_b),
    .reset_done   (done_b)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %b expected %b", tag, edge_n, obs, exp);
  endtask

  // One clock edge: apply inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic t);
    logic eff;
    logic req;
    rst  = r;
    trig = t;
    @(posedge clk);
    edge_n++;
`ifdef W5300_RESET_SYNC_EN
    eff = r ? 1'b0 : hist2;
    if (r) begin
      hist1 = 1'b0;
      hist2 = 1'b0;
    end else begin
      hist2 = hist1;
      hist1 = t;
    end
`else
    eff = t;
`endif
    req = eff && !prev_trig;
    prev_trig = r ? 1'b0 : eff;
    for (int i = 0; i < 2; i++) begin
      if (r || req) begin
        low_end[i]  = edge_n + lcyc[i];
        ready_at[i] = edge_n + lcyc[i] + rcyc[i];
      end
    end
    #1;
    check_bit("resetl_a", resetl_a, edge_n >= low_end[0]);
    check_bit("ready_a",  ready_a,  edge_n >= ready_at[0]);
    check_bit("done_a",   done_a,   edge_n == ready_at[0]);
    check_bit("resetl_b", resetl_b, edge_n >= low_end[1]);
    check_bit("ready_b",  ready_b,  edge_n >= ready_at[1]);
    check_bit("done_b",   done_b,   edge_n == ready_at[1]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    lcyc[0] = L0;
    rcyc[0] = R0;
    lcyc[1] = L1;
    rcyc[1] = R1;
    low_end[0]  = 0;
    low_end[1]  = 0;
    ready_at[0] = 0;
    ready_at[1] = 0;
    rst  = 1'b1;
    trig = 1'b0;

    // Power-up
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle_cycles(12);

    // Single one-cycle request
    step(1'b0, 1'b1);
    idle_cycles(12);

    // Held trigger: one sequence only
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    idle_cycles(12);

    // Retrigger two cycles into the pulse
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle_cycles(14);

    // Retrigger one cycle after resetl rises
    step(1'b0, 1'b1);
    idle_cycles(4);
    step(1'b0, 1'b1);
    idle_cycles(14);

    // rst mid-recovery
    step(1'b0, 1'b1);
    idle_cycles(5);
    step(1'b1, 1'b0);
    idle_cycles(14);

    // rst together with a request, then released with trigger still high
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    idle_cycles(14);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0));
    end
    idle_cycles(14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
